// File: rtl/sync_fifo_p_pkg.sv
// Shared definitions for the parametrised synchronous FIFO: default
// geometry, read-mode encodings and the per-cycle operation decode.
package sync_fifo_p_pkg;

  localparam int FIFO_DW_DEFAULT = 16;
  localparam int FIFO_AW_DEFAULT = 4;

  // Read-port behaviour selection
  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // What the FIFO actually does on a clock edge, after acceptance rules
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic wr_acc, input logic rd_acc);
    return fifo_op_e'({rd_acc, wr_acc});
  endfunction

endpackage

// File: rtl/sync_fifo_p_if.sv
// Producer/consumer handshake and status bundle of the synchronous FIFO.
// master = the block driving requests, slave = the FIFO itself.
interface sync_fifo_p_if
  import sync_fifo_p_pkg::*;
#(
  parameter int DW = FIFO_DW_DEFAULT,
  parameter int AW = FIFO_AW_DEFAULT
);

  logic          wr;
  logic [DW-1:0] din;
  logic          rd;
  logic          clr_err;

  logic [DW-1:0] dout;
  logic          valid;
  logic          full;
  logic          almostfull;
  logic          empty;
  logic          almostempty;
  logic [AW:0]   count;
  logic          over;
  logic          under;

  modport master (
    output wr, din, rd, clr_err,
    input  dout, valid, full, almostfull, empty, almostempty, count, over, under
  );

  modport slave (
    input  wr, din, rd, clr_err,
    output dout, valid, full, almostfull, empty, almostempty, count, over, under
  );

endinterface

// File: rtl/sync_fifo_p_ram.sv
// FIFO storage: DEPTH x DW register array, synchronous write, asynchronous
// read. Contents are intentionally not reset.
module fifo_ram #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 2**AW;

  logic [DW-1:0] mem_q [DEPTH];

  // Store the accepted write word
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Head word is always visible combinationally
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_p.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// levels, occupancy count, sticky overflow/underflow flags and an optional
// first-word-fall-through read port. Storage lives in fifo_ram; all control
// state (pointers, count, error flags, read register) lives here.
module sync_fifo_p
  import sync_fifo_p_pkg::*;
#(
  parameter int DW       = FIFO_DW_DEFAULT,
  parameter int AW       = FIFO_AW_DEFAULT,
  parameter int AF_LEVEL = (2**AW) - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = FIFO_MODE_STD
) (
  input  logic          clk,
  input  logic          rst,
  sync_fifo_p_if.slave  bus
);

  localparam int          DEPTH   = 2**AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

  // Catch unusable threshold / mode settings at elaboration
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_p: AF_LEVEL=%0d outside 1..%0d", AF_LEVEL, DEPTH);
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_p: AE_LEVEL=%0d outside 0..%0d", AE_LEVEL, DEPTH - 1);
  end
  if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
    $error("sync_fifo_p: FWFT=%0d is not a known read mode", FWFT);
  end

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          over_q, over_d;
  logic          under_q, under_d;

  logic          full;
  logic          empty;
  logic          wr_acc;
  logic          rd_acc;
  logic [DW-1:0] ram_rdata;

  // Status decode from the registered count; acceptance rules.
  // A write into a full FIFO is allowed when a read frees a slot this cycle.
  always_comb begin
    full   = (count_q == DEPTH_C);
    empty  = (count_q == '0);
    rd_acc = bus.rd && !empty;
    wr_acc = bus.wr && (!full || rd_acc);
  end

  // Next-state for pointers, occupancy and sticky error flags
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    unique case (fifo_op(wr_acc, rd_acc))
      OP_WRITE: begin
        wptr_d  = wptr_q + 1'b1;
        count_d = count_q + 1'b1;
      end
      OP_READ: begin
        rptr_d  = rptr_q + 1'b1;
        count_d = count_q - 1'b1;
      end
      OP_BOTH: begin
        wptr_d = wptr_q + 1'b1;
        rptr_d = rptr_q + 1'b1;
      end
      default: ;
    endcase

    // A new error in the same cycle as clr_err keeps the flag set
    if (bus.wr && !wr_acc) begin
      over_d = 1'b1;
    end else if (bus.clr_err) begin
      over_d = 1'b0;
    end else begin
      over_d = over_q;
    end

    if (bus.rd && !rd_acc) begin
      under_d = 1'b1;
    end else if (bus.clr_err) begin
      under_d = 1'b0;
    end else begin
      under_d = under_q;
    end
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      over_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      over_q  <= over_d;
      under_q <= under_d;
    end
  end

  fifo_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr_q),
    .wdata (bus.din),
    .raddr (rptr_q),
    .rdata (ram_rdata)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    // Head word presented directly; zero while empty so reset leaves dout=0
    assign bus.dout  = empty ? '0 : ram_rdata;
    assign bus.valid = !empty;
  end else begin : g_std
    logic [DW-1:0] dout_q, dout_d;
    logic          valid_q, valid_d;

    // Capture the head on an accepted read; valid pulses for one cycle
    always_comb begin
      valid_d = rd_acc;
      dout_d  = rd_acc ? ram_rdata : dout_q;
    end

    // Read data register
    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        dout_q  <= dout_d;
        valid_q <= valid_d;
      end
    end

    assign bus.dout  = dout_q;
    assign bus.valid = valid_q;
  end

  assign bus.count       = count_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almostfull  = (count_q >= AF_C);
  assign bus.almostempty = (count_q <= AE_C);
  assign bus.over        = over_q;
  assign bus.under       = under_q;

endmodule
